// File: rtl/food_spawner.sv
// Food-position generator: draws grid-aligned candidates from a free-running
// LFSR and commits one only when neither the snake nor another live food slot occupies it.
//
// state  | meaning
// IDLE   | waiting for gen with a legal slot
// PICK   | latch LFSR candidate, compare against other live slots
// QUERY  | ask the body checker about the candidate, wait for occ_ack
// COMMIT | write candidate into the target slot, pulse done
// FAIL   | redraw budget exhausted, pulse done+fail, slot untouched
module food_spawner #(
  parameter int          XW        = 10,
  parameter int          YW        = 10,
  parameter int          NUM_FOOD  = 2,
  parameter int          GRID_LOG2 = 3,
  parameter int          X_MIN     = 24,
  parameter int          X_MAX     = 632,
  parameter int          Y_MIN     = 56,
  parameter int          Y_MAX     = 440,
  parameter int          MAX_TRIES = 15,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gen,
  input  logic [1:0]             slot,
  input  logic [NUM_FOOD-1:0]    eat,
  output logic                   occ_req,
  output logic [XW-1:0]          occ_x,
  output logic [YW-1:0]          occ_y,
  input  logic                   occ_ack,
  input  logic                   occ_hit,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [NUM_FOOD*XW-1:0] food_x,
  output logic [NUM_FOOD*YW-1:0] food_y,
  output logic [NUM_FOOD-1:0]    food_valid
);

  localparam int CELL = 1 << GRID_LOG2;
  localparam int COLS = (X_MAX - X_MIN) / CELL + 1;
  localparam int ROWS = (Y_MAX - Y_MIN) / CELL + 1;
  localparam int CB   = $clog2(COLS);
  localparam int RB   = $clog2(ROWS);
  localparam int TW   = $clog2(MAX_TRIES + 2);

  if (CB + RB > 16) begin : g_bad_grid
    $error("food_spawner: grid needs more than 16 LFSR bits");
  end
  if (COLS < 2 || ROWS < 2) begin : g_bad_bounds
    $error("food_spawner: playfield must be at least 2x2 cells");
  end
  if (NUM_FOOD < 1 || NUM_FOOD > 4) begin : g_bad_slots
    $error("food_spawner: NUM_FOOD must be 1..4");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("food_spawner: SEED must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_QUERY,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr;
  logic [1:0]      tgt;
  logic [TW-1:0]   tries;
  logic            clash;
  logic [CB-1:0]   col_raw, col;
  logic [RB-1:0]   row_raw, row;
  logic [XW-1:0]   pick_x;
  logic [YW-1:0]   pick_y;
  logic            clash_c;
  logic            slot_ok;
  logic            ld_req, ld_cand, retry, commit;
  logic [XW-1:0]   fx [NUM_FOOD];
  logic [YW-1:0]   fy [NUM_FOOD];

  // A single conditional subtract folds the raw draw into range because
  // clog2 guarantees the raw value is below twice the cell count.
  assign col_raw = lfsr[CB-1:0];
  assign row_raw = lfsr[15 -: RB];
  assign col     = ({1'b0, col_raw} >= (CB+1)'(COLS)) ? col_raw - CB'(COLS) : col_raw;
  assign row     = ({1'b0, row_raw} >= (RB+1)'(ROWS)) ? row_raw - RB'(ROWS) : row_raw;
  assign pick_x  = XW'(X_MIN) + (XW'(col) << GRID_LOG2);
  assign pick_y  = YW'(Y_MIN) + (YW'(row) << GRID_LOG2);
  assign slot_ok = ({1'b0, slot} < 3'(NUM_FOOD));

  always_comb begin
    clash_c = 1'b0;
    for (int j = 0; j < NUM_FOOD; j++) begin
      if (tgt != 2'(j) && food_valid[j] && fx[j] == pick_x && fy[j] == pick_y)
        clash_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      lfsr  <= SEED;
    end else begin
      state <= state_nxt;
      lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    state_nxt = state;
    occ_req   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    fail      = 1'b0;
    ld_req    = 1'b0;
    ld_cand   = 1'b0;
    retry     = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (gen && slot_ok) begin
          ld_req    = 1'b1;
          state_nxt = S_PICK;
        end
      end
      S_PICK: begin
        ld_cand   = 1'b1;
        state_nxt = S_QUERY;
      end
      S_QUERY: begin
        occ_req = 1'b1;
        if (occ_ack) begin
          if (!(occ_hit || clash)) begin
            state_nxt = S_COMMIT;
          end else if (tries == TW'(MAX_TRIES)) begin
            state_nxt = S_FAIL;
          end else begin
            retry     = 1'b1;
            state_nxt = S_PICK;
          end
        end
      end
      S_COMMIT: begin
        done      = 1'b1;
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        done      = 1'b1;
        fail      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt   <= 2'd0;
      tries <= '0;
      occ_x <= XW'(X_MIN);
      occ_y <= YW'(Y_MIN);
      clash <= 1'b0;
    end else begin
      if (ld_req) begin
        tgt   <= slot;
        tries <= '0;
      end
      if (retry)
        tries <= tries + TW'(1);
      if (ld_cand) begin
        occ_x <= pick_x;
        occ_y <= pick_y;
        clash <= clash_c;
      end
    end
  end

  // The commit write takes priority over a same-cycle eat of the target slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FOOD; i++) begin
        fx[i] <= XW'(X_MIN);
        fy[i] <= YW'(Y_MIN);
      end
      food_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FOOD; i++) begin
        if (commit && tgt == 2'(i)) begin
          fx[i]         <= occ_x;
          fy[i]         <= occ_y;
          food_valid[i] <= 1'b1;
        end else if (eat[i]) begin
          food_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_FOOD; i++) begin : g_pack
    assign food_x[i*XW +: XW] = fx[i];
    assign food_y[i*YW +: YW] = fy[i];
  end

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: a responder plays the body checker and
// predicts each placement outcome; a monitor compares it when done pulses.
module tb_food_spawner;
  localparam int XW = 10, YW = 10, NF = 2, CELL = 8;
  localparam int XMIN = 24, XMAX = 632, YMIN = 56, YMAX = 440, MT = 15;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int COLS = (XMAX - XMIN) / CELL + 1;
  localparam int ROWS = (YMAX - YMIN) / CELL + 1;
  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);

  logic clk, reset, gen;
  logic [1:0] slot;
  logic [NF-1:0] eat;
  logic occ_req, occ_ack, occ_hit, busy, done, fail;
  logic [XW-1:0] occ_x;
  logic [YW-1:0] occ_y;
  logic [NF*XW-1:0] food_x;
  logic [NF*YW-1:0] food_y;
  logic [NF-1:0] food_valid;

  food_spawner #(.SEED(SEED)) dut (
    .clk(clk), .reset(reset), .gen(gen), .slot(slot), .eat(eat),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
    .busy(busy), .done(done), .fail(fail),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {bit fl; int s; int x; int y;} exp_t;
  exp_t exp_q[$];
  int   gen_q[$];

  int checks = 0, passed = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  // Reference model: polynomial x^16+x^14+x^13+x^11+1, cell = (low bits mod COLS, high bits mod ROWS)
  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic int draw_x(input logic [15:0] l);
    return XMIN + ((int'(l) % (1 << CB)) % COLS) * CELL;
  endfunction
  function automatic int draw_y(input logic [15:0] l);
    return YMIN + ((int'(l) >> (16 - RB)) % ROWS) * CELL;
  endfunction
  function automatic bit in_grid(input int x, input int y);
    return x >= XMIN && x <= XMAX && x % CELL == 0 && y >= YMIN && y <= YMAX && y % CELL == 0;
  endfunction
  function automatic int dut_x(input int i);
    return int'(food_x[i*XW +: XW]);
  endfunction
  function automatic int dut_y(input int i);
    return int'(food_y[i*YW +: YW]);
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= step(m_lfsr);
    end
  end

  int m_x [NF];
  int m_y [NF];
  bit m_v [NF];

  // Body-checker responder and outcome predictor
  int hit_mode, hit_n, ack_dly_max;
  bit ack_hold;
  bit in_q;
  int q_in_place = 0, wait_cnt, cur_slot, tries_m, cur_x, cur_y;
  int last_nq, place_clash;
  bit hitv, clash_m;

  always @(negedge clk) begin
    if (!reset) begin
      occ_ack = 1'b0; occ_hit = 1'b0; in_q = 1'b0; q_in_place = 0;
    end else if (occ_ack) begin
      occ_ack = 1'b0; occ_hit = 1'b0;
      check("req_drop_after_ack", occ_req, 0);
    end else if (occ_req) begin
      if (!in_q) begin
        in_q = 1'b1;
        if (q_in_place == 0) begin
          place_clash = 0; tries_m = 0;
          check("gen_pending", gen_q.size(), 1);
          cur_slot = (gen_q.size() > 0) ? gen_q.pop_front() : 0;
        end
        q_in_place++;
        cur_x = int'(occ_x); cur_y = int'(occ_y);
        check("cand_x", occ_x, draw_x(m_prev));
        check("cand_y", occ_y, draw_y(m_prev));
        check("cand_on_grid", in_grid(cur_x, cur_y), 1);
        wait_cnt = $urandom_range(ack_dly_max, 0);
      end else begin
        check("query_stable", (int'(occ_x) == cur_x && int'(occ_y) == cur_y), 1);
      end
      if (!ack_hold) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          hitv = (hit_mode == 0) ? ($urandom_range(3, 0) == 0) :
                 (hit_mode == 1) ? 1'b1 : (q_in_place <= hit_n);
          clash_m = 1'b0;
          for (int j = 0; j < NF; j++)
            if (j != cur_slot && m_v[j] && m_x[j] == cur_x && m_y[j] == cur_y) clash_m = 1'b1;
          if (clash_m) place_clash++;
          occ_ack = 1'b1; occ_hit = hitv; in_q = 1'b0;
          if (!hitv && !clash_m) begin
            exp_q.push_back('{1'b0, cur_slot, cur_x, cur_y});
            last_nq = q_in_place; q_in_place = 0;
          end else if (tries_m == MT) begin
            exp_q.push_back('{1'b1, cur_slot, m_x[cur_slot], m_y[cur_slot]});
            last_nq = q_in_place; q_in_place = 0;
          end else begin
            tries_m++;
          end
        end
      end
    end
  end

  // Monitor: pops the predicted outcome on done, checks slots one cycle later
  exp_t pend;
  bit   pend_v = 1'b0;
  int   dones = 0, last_fail = -1;
  always @(negedge clk) begin
    if (!reset) begin
      pend_v = 1'b0;
    end else if (done) begin
      check("done_has_exp", exp_q.size(), 1);
      check("busy_with_done", busy, 1);
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front(); pend_v = 1'b1; dones++; last_fail = int'(fail);
        check("fail_flag", fail, pend.fl);
      end
    end else if (pend_v) begin
      pend_v = 1'b0;
      check("slot_x", dut_x(pend.s), pend.x);
      check("slot_y", dut_y(pend.s), pend.y);
      check("slot_valid", food_valid[pend.s], pend.fl ? m_v[pend.s] : 1'b1);
      if (!pend.fl) begin
        m_x[pend.s] = pend.x; m_y[pend.s] = pend.y; m_v[pend.s] = 1'b1;
      end
      for (int j = 0; j < NF; j++) begin
        if (j != pend.s) begin
          check("other_x", dut_x(j), m_x[j]);
          check("other_y", dut_y(j), m_y[j]);
          check("other_valid", food_valid[j], m_v[j]);
        end
      end
    end
  end

  int placements = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!busy && !pend_v && exp_q.size() == 0 && gen_q.size() == 0 && !occ_ack) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic issue(input int s);
    gen = 1'b1; slot = 2'(s); gen_q.push_back(s); placements++;
    tick();
    gen = 1'b0;
  endtask

  task automatic place(input int s);
    issue(s);
    wait_idle();
  endtask

  task automatic eat_slot(input int s);
    eat = '0; eat[s] = 1'b1; m_v[s] = 1'b0;
    tick();
    eat = '0;
    check("eat_clear", food_valid[s], 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_x[i] = XMIN; m_y[i] = YMIN; m_v[i] = 1'b0;
    end
    exp_q.delete(); gen_q.delete(); pend_v = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [NF*XW-1:0] ex;
    logic [NF*YW-1:0] ey;
    for (int i = 0; i < NF; i++) begin
      ex[i*XW +: XW] = XW'(XMIN);
      ey[i*YW +: YW] = YW'(YMIN);
    end
    check({tag, "_food_x"}, food_x, ex);
    check({tag, "_food_y"}, food_y, ey);
    check({tag, "_valid"}, food_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_occ_req"}, occ_req, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && !occ_req; n++) tick();
    check("query_reached", occ_req, 1);
  endtask

  initial begin
    int d0, n, s;
    bit found;
    logic [15:0] l;
    reset = 1'b0; gen = 1'b0; slot = 2'd0; eat = '0;
    hit_mode = 2; hit_n = 0; ack_dly_max = 0; ack_hold = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (100) tick();
    check_reset_outputs("idle100");

    // Minimum latency: gen at T, PICK T+1, QUERY T+2, COMMIT T+3, valid T+4
    issue(0);
    check("lat_pick_req", occ_req, 0);
    check("lat_pick_busy", busy, 1);
    tick();
    check("lat_query_req", occ_req, 1);
    check("lat_query_done", done, 0);
    tick();
    check("lat_commit_done", done, 1);
    check("lat_commit_req", occ_req, 0);
    tick();
    check("lat_valid", food_valid, 2'b01);
    check("lat_done_drop", done, 0);
    wait_idle();

    // Two snake hits then a free cell
    hit_mode = 2; hit_n = 2; ack_dly_max = 3;
    place(1);
    if (place_clash == 0) check("retry_queries", last_nq, 3);
    check("retry_no_fail", last_fail, 0);

    // Snake everywhere: 1 + MAX_TRIES queries then fail
    hit_mode = 1;
    place(0);
    check("fail_queries", last_nq, MT + 1);
    check("fail_seen", last_fail, 1);
    check("fail_keep_x", dut_x(0), m_x[0]);
    check("fail_keep_valid", food_valid[0], m_v[0]);
    check("fail_not_busy", busy, 0);

    // Time gen so slot 0's first candidate lands on live slot 1
    hit_mode = 2; hit_n = 0; ack_dly_max = 2;
    l = m_lfsr; found = 1'b0;
    for (n = 0; n < 65535; n++) begin
      l = step(l);
      if (draw_x(l) == m_x[1] && draw_y(l) == m_y[1]) begin
        found = 1'b1;
        break;
      end
    end
    check("clash_target_found", found, 1);
    if (found) begin
      repeat (n) tick();
      place(0);
      check("clash_redraw", place_clash > 0, 1);
      check("clash_avoided", (dut_x(0) != m_x[1] || dut_y(0) != m_y[1]), 1);
    end

    // Eat of the target slot in its COMMIT cycle loses to the commit
    ack_dly_max = 0;
    issue(0);
    for (int k = 0; k < 200 && !done; k++) tick();
    check("commit_seen", done, 1);
    eat = 2'b01;
    tick();
    eat = '0;
    check("commit_beats_eat", food_valid[0], 1);
    wait_idle();

    // gen while busy is dropped
    ack_hold = 1'b1; d0 = dones;
    issue(1);
    wait_req();
    gen = 1'b1; slot = 2'd0;
    tick(); tick();
    gen = 1'b0;
    ack_hold = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("busy_gen_ignored", busy, 0);
    check("single_done", dones - d0, 1);

    // Reset in the middle of a query
    ack_hold = 1'b1;
    gen = 1'b1; slot = 2'd0; gen_q.push_back(0);
    tick();
    gen = 1'b0;
    wait_req();
    reset = 1'b0;
    #1;
    check("rst_req_drop", occ_req, 0);
    check("rst_busy_drop", busy, 0);
    ack_hold = 1'b0;
    tick(); tick();
    model_reset();
    check_reset_outputs("midrst");
    reset = 1'b1;
    tick();

    // Randomised mix of placements, eats and out-of-range requests
    hit_mode = 0; ack_dly_max = 3;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(5, 0))
        0, 1, 2, 3: place(int'($urandom_range(NF - 1, 0)));
        4: begin
          s = int'($urandom_range(NF - 1, 0));
          eat_slot(s);
        end
        default: begin
          gen = 1'b1; slot = 2'($urandom_range(3, NF));
          tick();
          gen = 1'b0;
          tick();
          check("bad_slot_ignored", busy, 0);
        end
      endcase
    end
    wait_idle();
    check("done_count", dones, placements);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
